q2a03_joypad_port: RTL and testbench
====================================

Name: q2a03_joypad_port

Overview:
- Bus responder for the Q2A03 CPU bus: decodes CPU reads/writes at $4016/$4017 and implements the NES controller-port protocol.
- Holds the strobe latch and one 8-bit serial shift register per pad; returns one button bit per read.
- Sits beside other bus responders; its rd_data is muxed onto G_rd_data when rd_hit is high.

Parameters:
- BASE_ADDR, 16'h4016, address of port 0; port 1 is BASE_ADDR+1.
- OPEN_BUS, 3'b010, constant driven on rd_data[7:5] for reads; with 3'b000 in bits 4:1 and the serial bit in bit 0, an idle read returns $41.

Ports:
- G_clock  in  1  system clock; same clock as the CPU.
- G_reset  in  1  reset.
- G_addr  in  16  CPU address bus.
- G_rdwr  in  1  1 = read, 0 = write.
- G_wr_data  in  8  CPU write data.
- G_phy2  in  1  CPU phase-2 clock; a bus cycle ends on its falling edge.
- G_ready  in  1  CPU RDY; low means the current cycle will be repeated.
- pad0_buttons  in  8  live pad 0 state, active-high pressed. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- pad1_buttons  in  8  live pad 1 state, same encoding.
- rd_data  out  8  read data toward the bus mux.
- rd_hit  out  1  high while a read addresses $4016 or $4017.
- strobe_out  out  1  current strobe latch, for external expansion.

Behaviour:
- Reset:
  - G_reset is asynchronous, active-low; clock is G_clock.
  - On reset: strobe=0, both shift regs=8'hff, phy2_q=1, rd_data=0, rd_hit=0.
- Edge detect:
  - phy2_q is G_phy2 registered on G_clock.
  - fall = phy2_q & ~G_phy2; all bus side effects happen only on the G_clock edge where fall is true.
- Decode:
  - sel0 = (G_addr == BASE_ADDR); sel1 = (G_addr == BASE_ADDR+1).
- Read path (combinational, valid the whole cycle):
  - rd_hit = G_rdwr & (sel0 | sel1).
  - rd_data = {OPEN_BUS, 4'b0000, sr0[0] (sel0) or sr1[0] (sel1)}.
  - rd_data = 0 when rd_hit=0.
- Shift:
  - Condition: fall & G_rdwr & G_ready & strobe==0 & selN.
  - Action: srN <= {1'b1, srN[7:1]}.
  - The shift takes effect after the cycle ends; a later read sees the next bit.
  - After 8 shifts all reads return 1 until the next reload.
  - Exactly one shift per bus cycle, however long phy2 is high.
- Write:
  - On fall & ~G_rdwr & sel0: strobe <= G_wr_data[0].
  - Writes to $4017 are ignored (APU frame counter owns them); no shift or strobe change.
- Reload:
  - While strobe==1, sr0 <= pad0_buttons and sr1 <= pad1_buttons every G_clock.
  - Reads during strobe=1 return live A without shifting.
  - The strobe 1->0 write freezes the value loaded on that same edge.
- RDY low: a read on the falling edge with G_ready=0 does not shift. The repeated cycle returns the same bit.
- Simultaneous events:
  - A write clearing strobe on the same edge as a reload: the reload wins on that edge, then strobe=0 takes effect.
  - Buttons changing while strobe=0 have no effect.
- Reset mid-sequence: registers return to reset values immediately; following reads return 1 until the next strobe.
- Latency:
  - Read data: 0 G_clock (combinational from registers).
  - Strobe and shift: 1 G_clock after the phy2 fall edge is seen.

Decomposition:
- Package q2a03_bus_pkg:
  - reg8_type/reg16_type typedefs.
  - JOY0_ADDR = 16'h4016, JOY1_ADDR = 16'h4017.
  - Button bit indices BTN_A..BTN_RIGHT.
  - RDWR_READ = 1'b1.
- Sub-module q2a03_pad_shifter, instantiated twice.
  - Inputs: clock, reset, strobe, shift_en, buttons[7:0].
  - Output: serial bit = sr[0].
  - Holds the 8-bit register and the reload/shift/fill-with-1 logic.
- Top level holds edge detect, decode, strobe latch and read mux.

Test Plan:
- Reset then read $4016 with no strobe write -> rd_data=$41 on every read; rd_hit=1 on each read cycle.
- pad0_buttons=8'b0000_1001 (A+Start); write $01 then $00 to $4016; 8 reads of $4016 -> bit0 sequence 1,0,0,1,0,0,0,0; reads 9-10 -> 1.
- pad1_buttons=8'h80 (Right), pad0=8'h00; strobe pulse; interleave reads $4017 and $4016 -> $4017 gives 0x7 then 1; $4016 all 0; the shift registers are independent.
- strobe=1 held, pad0 toggles A 0->1->0 between reads -> each read returns live A ($40/$41); no shift occurs.
- Read $4016 with G_ready=0 for 3 consecutive cycles, then G_ready=1 -> the same bit is returned all 4 times; one shift only after the ready cycle.
- Assert G_reset after 3 shifts, release, read $4016 -> $41; write $00 to $4017 -> strobe_out stays 0; a read of $4015 -> rd_hit=0, rd_data=0.

Source files
------------

// File: rtl/q2a03_bus_pkg.sv
// q2a03_bus_pkg
//   Shared types and constants for Q2A03 CPU-bus responders: register
//   typedefs, the controller-port addresses, controller button bit indices
//   and the read/write encoding of the CPU RW line.
package q2a03_bus_pkg;

    typedef logic [7:0]  reg8_type;
    typedef logic [15:0] reg16_type;

    localparam reg16_type JOY0_ADDR = 16'h4016;
    localparam reg16_type JOY1_ADDR = 16'h4017;

    // Button positions inside a pad byte (also the serial shift-out order).
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic RDWR_READ = 1'b1;

endpackage

// File: rtl/q2a03_pad_shifter.sv
// q2a03_pad_shifter
//   One controller's 8-bit parallel-in / serial-out shift register.
//   While strobe_i is high the register follows the live buttons every
//   clock; while low, each shift_en_i pulse moves the next button into bit 0
//   and fills from the top with 1, so reads past the eighth return 1.
// Ports:
//   G_clock    in   system clock
//   G_reset    in   asynchronous active-low reset (register -> 8'hff)
//   strobe_i   in   reload enable (strobe latch)
//   shift_en_i in   one-clock shift request
//   buttons_i  in   live pad state, active-high pressed
//   serial_o   out  current serial bit (register bit 0)
module q2a03_pad_shifter
    import q2a03_bus_pkg::*;
(
    input  logic       G_clock,
    input  logic       G_reset,
    input  logic       strobe_i,
    input  logic       shift_en_i,
    input  logic [7:0] buttons_i,
    output logic       serial_o
);

    reg8_type sr_q;
    reg8_type sr_d;

    // Reload has priority: a strobe-clearing write on the same edge still
    // captures the buttons, and that captured value is what gets shifted out.
    always_comb begin
        sr_d = sr_q;
        if (strobe_i) begin
            sr_d = buttons_i;
        end else if (shift_en_i) begin
            sr_d = {1'b1, sr_q[7:1]};
        end
    end

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            sr_q <= 8'hff;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_o = sr_q[BTN_A];

endmodule

// File: rtl/q2a03_joypad_port.sv
// q2a03_joypad_port
//   CPU-bus responder for the two controller ports ($4016/$4017).
//   Detects the end of each bus cycle (falling edge of phi2 sampled on
//   G_clock), latches the strobe on writes to $4016, advances a pad's shift
//   register on each completed read of its port, and returns the serial bit
//   combinationally with open-bus upper bits.
// Ports:
//   G_clock, G_reset       system clock, asynchronous active-low reset
//   G_addr, G_rdwr         CPU address, RW (1 = read)
//   G_wr_data              CPU write data
//   G_phy2                 CPU phase-2 clock
//   G_ready                CPU RDY (low = cycle will repeat)
//   pad0/pad1_buttons      live pad states, active-high pressed
//   rd_data, rd_hit        read data and select toward the bus mux
//   strobe_out             current strobe latch
module q2a03_joypad_port
    import q2a03_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = JOY0_ADDR,
    parameter logic [2:0]  OPEN_BUS  = 3'b010
)(
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    input  logic        G_phy2,
    input  logic        G_ready,
    input  logic [7:0]  pad0_buttons,
    input  logic [7:0]  pad1_buttons,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        strobe_out
);

    logic phy2_q;
    logic strobe_q;
    logic strobe_d;
    logic fall;
    logic sel0;
    logic sel1;
    logic is_read;
    logic shift0_en;
    logic shift1_en;
    logic serial0;
    logic serial1;
    logic unused_wr_data;

    assign unused_wr_data = ^G_wr_data[7:1];

    // A bus cycle completes on the falling edge of phi2; every side effect
    // is keyed to this single-clock pulse, so a long phi2-high period still
    // produces exactly one shift.
    assign fall    = phy2_q & ~G_phy2;
    assign sel0    = (G_addr == BASE_ADDR);
    assign sel1    = (G_addr == (BASE_ADDR + 16'd1));
    assign is_read = (G_rdwr == RDWR_READ);

    // RDY low means the CPU repeats this read, so it must not consume a bit.
    assign shift0_en = fall & is_read & G_ready & ~strobe_q & sel0;
    assign shift1_en = fall & is_read & G_ready & ~strobe_q & sel1;

    // Only $4016 writes touch the strobe; $4017 writes belong to the APU.
    always_comb begin
        strobe_d = strobe_q;
        if (fall && !is_read && sel0) begin
            strobe_d = G_wr_data[0];
        end
    end

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            phy2_q   <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            phy2_q   <= G_phy2;
            strobe_q <= strobe_d;
        end
    end

    q2a03_pad_shifter u_pad0 (
        .G_clock    (G_clock),
        .G_reset    (G_reset),
        .strobe_i   (strobe_q),
        .shift_en_i (shift0_en),
        .buttons_i  (pad0_buttons),
        .serial_o   (serial0)
    );

    q2a03_pad_shifter u_pad1 (
        .G_clock    (G_clock),
        .G_reset    (G_reset),
        .strobe_i   (strobe_q),
        .shift_en_i (shift1_en),
        .buttons_i  (pad1_buttons),
        .serial_o   (serial1)
    );

    assign rd_hit = is_read & (sel0 | sel1);

    always_comb begin
        rd_data = 8'h00;
        if (rd_hit) begin
            rd_data = {OPEN_BUS, 4'b0000, (sel0 ? serial0 : serial1)};
        end
    end

    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_q2a03_joypad_port.sv
module tb_q2a03_joypad_port;

    logic        G_clock;
    logic        G_reset;
    logic [15:0] G_addr;
    logic        G_rdwr;
    logic [7:0]  G_wr_data;
    logic        G_phy2;
    logic        G_ready;
    logic [7:0]  pad0_buttons;
    logic [7:0]  pad1_buttons;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        strobe_out;

    int checks = 0;
    int errors = 0;

    q2a03_joypad_port dut (
        .G_clock      (G_clock),
        .G_reset      (G_reset),
        .G_addr       (G_addr),
        .G_rdwr       (G_rdwr),
        .G_wr_data    (G_wr_data),
        .G_phy2       (G_phy2),
        .G_ready      (G_ready),
        .pad0_buttons (pad0_buttons),
        .pad1_buttons (pad1_buttons),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .strobe_out   (strobe_out)
    );

    initial G_clock = 1'b0;
    always #5 G_clock = ~G_clock;

    // One CPU bus cycle: phi2 high for two clocks (outputs sampled at the end
    // of that window), then phi2 falls and one more clock lets the edge act.
    task automatic bus_cycle(input logic [15:0] addr, input logic rdwr,
                             input logic [7:0] wdata, input logic ready,
                             output logic [7:0] data, output logic hit);
        @(negedge G_clock);
        G_addr    = addr;
        G_rdwr    = rdwr;
        G_wr_data = wdata;
        G_ready   = ready;
        G_phy2    = 1'b1;
        @(negedge G_clock);
        @(negedge G_clock);
        data   = rd_data;
        hit    = rd_hit;
        G_phy2 = 1'b0;
        @(negedge G_clock);
        G_addr = 16'h0000;
        G_rdwr = 1'b1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] wdata);
        logic [7:0] d;
        logic       h;
        bus_cycle(addr, 1'b0, wdata, 1'b1, d, h);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       h;
        if (strobe_out !== 1'b0) begin
            errors++; $display("FAIL reset_strobe actual=%b required=0", strobe_out);
        end
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_idle actual=%b/%h required=0/00", rd_hit, rd_data);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
            if (d !== 8'h41 || h !== 1'b1) begin
                errors++; $display("FAIL reset_read%0d actual=%h/%b required=41/1", i, d, h);
            end
            checks++;
        end
    endtask

    task automatic test_serial_sequence();
        logic [7:0] d;
        logic       h;
        logic [7:0] exp_bits [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40,
                                      8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
        pad0_buttons = 8'b0000_1001;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        pad0_buttons = 8'hff;   // post-latch changes must be ignored
        for (int i = 0; i < 10; i++) begin
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
            if (d !== exp_bits[i] || h !== 1'b1) begin
                errors++; $display("FAIL serial_read%0d actual=%h/%b required=%h/1", i, d, h, exp_bits[i]);
            end
            checks++;
        end
    endtask

    task automatic test_two_pads();
        logic [7:0] d;
        logic       h;
        logic [7:0] exp1;
        pad0_buttons = 8'h00;
        pad1_buttons = 8'h80;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) begin
            exp1 = (i == 7) ? 8'h41 : 8'h40;
            bus_cycle(16'h4017, 1'b1, 8'h00, 1'b1, d, h);
            if (d !== exp1 || h !== 1'b1) begin
                errors++; $display("FAIL pad1_read%0d actual=%h/%b required=%h/1", i, d, h, exp1);
            end
            checks++;
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
            if (d !== 8'h40) begin
                errors++; $display("FAIL pad0_read%0d actual=%h required=40", i, d);
            end
            checks++;
        end
        bus_cycle(16'h4017, 1'b1, 8'h00, 1'b1, d, h);
        if (d !== 8'h41) begin
            errors++; $display("FAIL pad1_read8 actual=%h required=41", d);
        end
        checks++;
    endtask

    task automatic test_strobe_held();
        logic [7:0] d;
        logic       h;
        logic [7:0] pads [3] = '{8'h00, 8'h01, 8'h00};
        logic [7:0] exps [3] = '{8'h40, 8'h41, 8'h40};
        wr(16'h4016, 8'h01);
        if (strobe_out !== 1'b1) begin
            errors++; $display("FAIL strobe_set actual=%b required=1", strobe_out);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            pad0_buttons = pads[i];
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
            if (d !== exps[i]) begin
                errors++; $display("FAIL live_read%0d actual=%h required=%h", i, d, exps[i]);
            end
            checks++;
        end
        // Strobe=1 with $00 to $4017 must not touch the strobe.
        wr(16'h4017, 8'h00);
        if (strobe_out !== 1'b1) begin
            errors++; $display("FAIL joy1_write_held actual=%b required=1", strobe_out);
        end
        checks++;
        wr(16'h4016, 8'h00);
    endtask

    task automatic test_ready_low();
        logic [7:0] d;
        logic       h;
        pad0_buttons = 8'b0000_0010;  // B only: first bit 0, second bit 1
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b0, d, h);
            if (d !== 8'h40) begin
                errors++; $display("FAIL rdy_low_read%0d actual=%h required=40", i, d);
            end
            checks++;
        end
        bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
        if (d !== 8'h40) begin
            errors++; $display("FAIL rdy_high_read actual=%h required=40", d);
        end
        checks++;
        bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
        if (d !== 8'h41) begin
            errors++; $display("FAIL rdy_next_bit actual=%h required=41", d);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       h;
        pad0_buttons = 8'h00;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
        end
        wr(16'h4016, 8'h01);
        @(negedge G_clock);
        #2 G_reset = 1'b0;
        #1;
        if (strobe_out !== 1'b0) begin
            errors++; $display("FAIL async_reset_strobe actual=%b required=0", strobe_out);
        end
        checks++;
        @(negedge G_clock);
        G_reset = 1'b1;
        bus_cycle(16'h4016, 1'b1, 8'h00, 1'b1, d, h);
        if (d !== 8'h41) begin
            errors++; $display("FAIL post_reset_read actual=%h required=41", d);
        end
        checks++;
        wr(16'h4017, 8'h01);
        if (strobe_out !== 1'b0) begin
            errors++; $display("FAIL joy1_write_ignored actual=%b required=0", strobe_out);
        end
        checks++;
        bus_cycle(16'h4015, 1'b1, 8'h00, 1'b1, d, h);
        if (h !== 1'b0 || d !== 8'h00) begin
            errors++; $display("FAIL other_addr actual=%b/%h required=0/00", h, d);
        end
        checks++;
    endtask

    initial begin
        G_reset      = 1'b0;
        G_addr       = 16'h0000;
        G_rdwr       = 1'b1;
        G_wr_data    = 8'h00;
        G_phy2       = 1'b0;
        G_ready      = 1'b1;
        pad0_buttons = 8'h00;
        pad1_buttons = 8'h00;
        repeat (3) @(negedge G_clock);
        G_reset = 1'b1;
        @(negedge G_clock);
        test_reset();
        test_serial_sequence();
        test_two_pads();
        test_strobe_held();
        test_ready_low();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
